// File: rtl/mips32_instr_sequencer_pkg.sv
// Shared definitions for the mips32 instruction sequencer: word width, end marker
// and the sequencer state encoding.
package mips32_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] END_MARKER = 32'h0;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic logic is_end_marker(input logic [INSTR_W-1:0] word);
    return word == END_MARKER;
  endfunction

endpackage

// File: rtl/mips32_instr_sequencer_if.sv
// Host-side bus of the sequencer: program load, run control and the result stream.
// Result handshake: an entry transfers on a rising edge where res_valid && res_ready;
// res_valid never drops and res_pc/res_instr/res_data never change until that edge.
interface mips32_instr_sequencer_if #(
  parameter int ADDR_W = 4
);
  import mips32_pkg::*;

  logic               load_en;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic               start;
  logic               res_valid;
  logic               res_ready;
  logic [ADDR_W-1:0]  res_pc;
  logic [INSTR_W-1:0] res_instr;
  logic [INSTR_W-1:0] res_data;
  logic               busy;
  logic               done;
  logic [ADDR_W:0]    issued_cnt;

  modport master (
    output load_en, load_addr, load_data, start, res_ready,
    input  res_valid, res_pc, res_instr, res_data, busy, done, issued_cnt
  );

  modport slave (
    input  load_en, load_addr, load_data, start, res_ready,
    output res_valid, res_pc, res_instr, res_data, busy, done, issued_cnt
  );

endinterface

// File: rtl/mips32_instr_sequencer_mem.sv
// Program store: DEPTH x 32 words, synchronous write, two asynchronous read ports
// (current entry and the look-ahead entry used for end-marker detection).
module mips32_prog_mem
  import mips32_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]  raddr_a_i,
  output logic [INSTR_W-1:0] rdata_a_o,
  input  logic [ADDR_W-1:0]  raddr_b_i,
  output logic [INSTR_W-1:0] rdata_b_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  // Contents deliberately survive reset so a program can be replayed.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/mips32_instr_sequencer.sv
// Steps a loaded program through the combinational mips32 core one instruction at a
// time and streams {pc, instruction, result} to a consumer over a valid/ready port.
module mips32_instr_sequencer
  import mips32_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mips32_instr_sequencer_if.slave bus,
  output logic [INSTR_W-1:0]      instruction_set,
  input  logic [INSTR_W-1:0]      result,
  output logic [STATE_W-1:0]      dbg_state_o
);

  localparam logic [3:0]        SETTLE_INIT = 4'(SETTLE - 1);
  localparam logic [ADDR_W-1:0] LAST_PC     = ADDR_W'(DEPTH - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               res_valid_q, res_valid_d;
  logic [ADDR_W-1:0]  res_pc_q, res_pc_d;
  logic [INSTR_W-1:0] res_instr_q, res_instr_d;
  logic [INSTR_W-1:0] res_data_q, res_data_d;
  logic [ADDR_W:0]    issued_q, issued_d;

  logic [INSTR_W-1:0] mem_cur;
  logic [INSTR_W-1:0] mem_next;
  logic               mem_we;

  assign mem_we = bus.load_en && (state_q == ST_IDLE);

  mips32_prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .we_i      (mem_we),
    .waddr_i   (bus.load_addr),
    .wdata_i   (bus.load_data),
    .raddr_a_i (pc_q),
    .rdata_a_o (mem_cur),
    .raddr_b_i (pc_q + ADDR_W'(1)),
    .rdata_b_o (mem_next)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    instr_d     = instr_q;
    res_valid_d = res_valid_q;
    res_pc_d    = res_pc_q;
    res_instr_d = res_instr_q;
    res_data_d  = res_data_q;
    issued_d    = issued_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_ISSUE;
          pc_d     = '0;
          issued_d = '0;
        end
      end
      ST_ISSUE: begin
        instr_d = mem_cur;
        cnt_d   = SETTLE_INIT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // The core is combinational; result is sampled once it has had SETTLE cycles.
        if (cnt_q == '0) begin
          res_valid_d = 1'b1;
          res_pc_d    = pc_q;
          res_instr_d = instr_q;
          res_data_d  = result;
          state_d     = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          issued_d    = issued_q + 1'b1;
          // Entry 0 always runs; afterwards a zero word or the last slot ends the run.
          if (pc_q == LAST_PC || is_end_marker(mem_next)) begin
            state_d = ST_DONE;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          state_d  = ST_ISSUE;
          pc_d     = '0;
          issued_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      cnt_q       <= '0;
      instr_q     <= '0;
      res_valid_q <= 1'b0;
      res_pc_q    <= '0;
      res_instr_q <= '0;
      res_data_q  <= '0;
      issued_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      instr_q     <= instr_d;
      res_valid_q <= res_valid_d;
      res_pc_q    <= res_pc_d;
      res_instr_q <= res_instr_d;
      res_data_q  <= res_data_d;
      issued_q    <= issued_d;
    end
  end

  assign instruction_set = instr_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_pc      = res_pc_q;
  assign bus.res_instr   = res_instr_q;
  assign bus.res_data    = res_data_q;
  assign bus.busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_HOLD);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.issued_cnt  = issued_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_mips32_instr_sequencer.sv
// Directed bench for mips32_instr_sequencer with a behavioural R-type core on the
// instruction_set/result loop.
module tb_mips32_instr_sequencer;
  import mips32_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int W      = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [W-1:0]       instruction_set;
  logic [W-1:0]       result;
  logic [STATE_W-1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] exp_pc_q[$];
  logic [W-1:0]      exp_instr_q[$];
  logic [W-1:0]      exp_q[$];
  logic [W-1:0]      prog_full [DEPTH];

  mips32_instr_sequencer_if #(.ADDR_W(ADDR_W)) bus_if ();

  mips32_instr_sequencer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .SETTLE (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus_if.slave),
    .instruction_set (instruction_set),
    .result          (result),
    .dbg_state_o     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // register file seen by the core: r0=0, rN = N*0x1000 + 5
  function automatic logic [W-1:0] reg_val(input logic [4:0] idx);
    if (idx == 5'd0) return '0;
    return ({27'b0, idx} * 32'h1000) + 32'h5;
  endfunction

  function automatic logic [W-1:0] core_model(input logic [W-1:0] w);
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = reg_val(w[25:21]);
    b = reg_val(w[20:16]);
    case (w[5:0])
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24:        return a & b;
      6'h25:        return a | b;
      6'h27:        return ~(a | b);
      6'h00:        return b << w[10:6];
      6'h02:        return b >> w[10:6];
      6'h2b:        return {31'b0, a < b};
      default:      return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] mk_r(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  always_comb result = core_model(instruction_set);

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] addr, input logic [W-1:0] data);
    bus_if.load_en   = 1'b1;
    bus_if.load_addr = addr;
    bus_if.load_data = data;
    tick();
    bus_if.load_en   = 1'b0;
  endtask

  task automatic pulse_start();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] pc, input logic [W-1:0] instr,
                          input logic [W-1:0] data);
    exp_pc_q.push_back(pc);
    exp_instr_q.push_back(instr);
    exp_q.push_back(data);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int cyc = 0;
    while (!bus_if.res_valid && cyc < budget) begin
      tick();
      cyc++;
    end
    check(tag, {31'b0, bus_if.res_valid}, 32'd1);
  endtask

  // scoreboard: every handshaken entry is matched against the head of the expected queue
  task automatic collect(input string tag, input int budget);
    int cyc = 0;
    while (!bus_if.done && cyc < budget) begin
      if (bus_if.res_valid && bus_if.res_ready) begin
        check({tag, "_entry_expected"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check({tag, "_res_pc"},    {28'b0, bus_if.res_pc}, {28'b0, exp_pc_q.pop_front()});
          check({tag, "_res_instr"}, bus_if.res_instr, exp_instr_q.pop_front());
          check({tag, "_res_data"},  bus_if.res_data, exp_q.pop_front());
        end
      end
      tick();
      cyc++;
    end
    check({tag, "_done"}, {31'b0, bus_if.done}, 32'd1);
    check({tag, "_entries_left"}, 32'(exp_q.size()), 32'd0);
    exp_pc_q.delete();
    exp_instr_q.delete();
    exp_q.delete();
  endtask

  localparam logic [W-1:0] I_ADD = 32'h0211_9020;  // r18 = r16 + r17
  localparam logic [W-1:0] I_SUB = 32'h01AE_6022;  // r12 = r13 - r14
  localparam logic [W-1:0] R_ADD = 32'h0002_100A;  // 0x10005 + 0x11005
  localparam logic [W-1:0] R_SUB = 32'hFFFF_F000;  // 0xD005 - 0xE005

  initial begin
    int lat;
    bus_if.load_en   = 1'b0;
    bus_if.load_addr = '0;
    bus_if.load_data = '0;
    bus_if.start     = 1'b0;
    bus_if.res_ready = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_state",      {29'b0, dbg_state}, {29'b0, ST_IDLE});
    check("rst_res_valid",  {31'b0, bus_if.res_valid}, 32'd0);
    check("rst_busy",       {31'b0, bus_if.busy}, 32'd0);
    check("rst_done",       {31'b0, bus_if.done}, 32'd0);
    check("rst_issued",     {27'b0, bus_if.issued_cnt}, 32'd0);
    check("rst_instr_set",  instruction_set, 32'd0);
    check("rst_res_data",   bus_if.res_data, 32'd0);
    check("rst_res_instr",  bus_if.res_instr, 32'd0);
    rst_n = 1'b1;
    tick();

    // two-instruction program with end marker
    load_word(4'd0, I_ADD);
    load_word(4'd1, I_SUB);
    load_word(4'd2, 32'h0);
    bus_if.res_ready = 1'b1;
    push_exp(4'd0, I_ADD, R_ADD);
    push_exp(4'd1, I_SUB, R_SUB);
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    lat = 1;
    while (!bus_if.res_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("first_valid_latency", 32'(lat), 32'd4);
    collect("basic", 50);
    check("basic_issued", {27'b0, bus_if.issued_cnt}, 32'd2);
    check("basic_busy",   {31'b0, bus_if.busy}, 32'd0);

    // start and load pulsed during WAIT are ignored
    push_exp(4'd0, I_ADD, R_ADD);
    push_exp(4'd1, I_SUB, R_SUB);
    pulse_start();
    tick();
    check("ign_in_wait", {29'b0, dbg_state}, {29'b0, ST_WAIT});
    bus_if.start     = 1'b1;
    bus_if.load_en   = 1'b1;
    bus_if.load_addr = 4'd1;
    bus_if.load_data = 32'hDEAD_BEEF;
    tick();
    bus_if.start   = 1'b0;
    bus_if.load_en = 1'b0;
    check("ign_busy", {31'b0, bus_if.busy}, 32'd1);
    collect("ignored", 50);
    check("ign_issued", {27'b0, bus_if.issued_cnt}, 32'd2);

    // backpressure on entry 0
    bus_if.res_ready = 1'b0;
    pulse_start();
    wait_valid("bp_valid", 20);
    for (int i = 0; i < 10; i++) begin
      check("bp_res_valid", {31'b0, bus_if.res_valid}, 32'd1);
      check("bp_res_pc",    {28'b0, bus_if.res_pc}, 32'd0);
      check("bp_res_instr", bus_if.res_instr, I_ADD);
      check("bp_res_data",  bus_if.res_data, R_ADD);
      check("bp_instr_set", instruction_set, I_ADD);
      tick();
    end
    check("bp_issued", {27'b0, bus_if.issued_cnt}, 32'd0);
    push_exp(4'd0, I_ADD, R_ADD);
    push_exp(4'd1, I_SUB, R_SUB);
    bus_if.res_ready = 1'b1;
    collect("bp_resume", 50);
    check("bp_final_issued", {27'b0, bus_if.issued_cnt}, 32'd2);

    // asynchronous reset while holding an entry
    bus_if.res_ready = 1'b0;
    pulse_start();
    wait_valid("hold_valid", 20);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_res_valid", {31'b0, bus_if.res_valid}, 32'd0);
    check("mid_rst_state",     {29'b0, dbg_state}, {29'b0, ST_IDLE});
    check("mid_rst_busy",      {31'b0, bus_if.busy}, 32'd0);
    check("mid_rst_instr_set", instruction_set, 32'd0);
    check("mid_rst_res_pc",    {28'b0, bus_if.res_pc}, 32'd0);
    check("mid_rst_issued",    {27'b0, bus_if.issued_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.res_ready = 1'b1;
    tick();
    check("post_rst_idle", {29'b0, dbg_state}, {29'b0, ST_IDLE});
    push_exp(4'd0, I_ADD, R_ADD);
    push_exp(4'd1, I_SUB, R_SUB);
    pulse_start();
    collect("replay", 50);
    check("replay_issued", {27'b0, bus_if.issued_cnt}, 32'd2);

    // full 16-entry program, no end marker
    prog_full[0]  = mk_r(1, 2, 3, 0, 'h20);
    prog_full[1]  = mk_r(4, 5, 6, 0, 'h21);
    prog_full[2]  = mk_r(9, 3, 7, 0, 'h22);
    prog_full[3]  = mk_r(3, 9, 8, 0, 'h23);
    prog_full[4]  = mk_r(10, 12, 11, 0, 'h24);
    prog_full[5]  = mk_r(10, 12, 13, 0, 'h25);
    prog_full[6]  = mk_r(10, 12, 14, 0, 'h27);
    prog_full[7]  = mk_r(0, 15, 16, 4, 'h00);
    prog_full[8]  = mk_r(0, 20, 17, 3, 'h02);
    prog_full[9]  = mk_r(2, 7, 18, 0, 'h2b);
    prog_full[10] = mk_r(7, 2, 19, 0, 'h2b);
    prog_full[11] = mk_r(31, 30, 1, 0, 'h20);
    prog_full[12] = mk_r(0, 0, 2, 0, 'h27);
    prog_full[13] = mk_r(31, 1, 4, 0, 'h23);
    prog_full[14] = mk_r(0, 31, 5, 31, 'h00);
    prog_full[15] = mk_r(16, 17, 18, 0, 'h21);
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      load_word(4'(i), prog_full[i]);
      push_exp(4'(i), prog_full[i], core_model(prog_full[i]));
    end
    pulse_start();
    collect("full", 200);
    check("full_issued", {27'b0, bus_if.issued_cnt}, 32'd16);
    check("full_last_pc", {28'b0, bus_if.res_pc}, 32'd15);
    repeat (5) tick();
    check("full_stays_done", {29'b0, dbg_state}, {29'b0, ST_DONE});
    check("full_no_wrap_valid", {31'b0, bus_if.res_valid}, 32'd0);
    check("full_issued_hold", {27'b0, bus_if.issued_cnt}, 32'd16);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
